row_window_fifo: RTL and testbench
==================================

Name: row_window_fifo

Overview:
Parametrised circular FIFO for streaming pixel and activation rows into convolution windows.
- Accepts one word per cycle.
- Pops either one word or a whole row step of ROW_SHIFT words per cycle.
- Exposes the oldest WINDOW entries in parallel for window builders.
- Adds a configurable word width, decoupled window and step sizes, flush, and overflow/underflow reporting.

Parameters:
DATA_WIDTH, 8, bits per entry
DEPTH, 16, storage entries; must be ≥ 2
ROW_SHIFT, 3, entries removed by pop_row; 1 ≤ ROW_SHIFT ≤ DEPTH
WINDOW, 3, entries presented on window_out; 1 ≤ WINDOW ≤ DEPTH
CW, $clog2(DEPTH+1), occupancy counter width (local)

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
push  in  1  write push_data this cycle
push_data  in  DATA_WIDTH  entry to write
pop  in  1  remove one entry
pop_row  in  1  remove ROW_SHIFT entries
flush  in  1  synchronous clear of contents
data_out  out  DATA_WIDTH  oldest entry; 0 when empty
window_out  out  WINDOW*DATA_WIDTH  entry i (0 = oldest) at bits [i*DATA_WIDTH +: DATA_WIDTH]
window_valid  out  1  count ≥ WINDOW
row_shift_rdy  out  1  count ≥ ROW_SHIFT
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  one-cycle pulse: push rejected
underflow  out  1  one-cycle pulse: pop or pop_row rejected

Behaviour:
- Storage is a circular buffer with head pointer, tail pointer and a CW-bit count. Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Reset (async, reset == 0): pointers = 0, count = 0, all storage = 0, overflow = 0, underflow = 0, so empty = 1 and full = 0.
- data_out, window_out, window_valid, row_shift_rdy, full and empty are combinational from registered state. Any window slot i ≥ count reads 0.
- Latency: a word pushed at edge N appears on data_out/window_out after edge N if it is the oldest entry. Pop effects are visible after the same edge.
- Per-cycle priority order:
  1. flush: count and pointers go to 0, and push/pop/pop_row are ignored. Storage is not cleared, only masked by count. No error pulses.
  2. pop_row overrides pop; when both are high, pop is ignored and never flagged.
- Removal request:
  - pop_row with count ≥ ROW_SHIFT: head += ROW_SHIFT (mod DEPTH), count -= ROW_SHIFT.
  - pop_row with count < ROW_SHIFT: ignored, underflow = 1 next cycle.
  - pop with count ≥ 1: head += 1.
  - pop with count == 0: ignored, underflow = 1.
- Push:
  - Accepted if count < DEPTH, or if an accepted removal occurs in the same cycle.
  - Otherwise rejected, with overflow = 1 next cycle.
  - An accepted push writes storage[tail] and advances tail.
- A push into an empty FIFO with a simultaneous pop is accepted; the pop is rejected and flagged.
- count_next = count + push_acc − (pop_acc ? 1 : 0) − (row_acc ? ROW_SHIFT : 0). No intermediate value leaves the range [0, DEPTH].
- overflow and underflow are registered. They are high for exactly the cycle after the offending request and low otherwise.
- Reset asserted mid-operation clears everything immediately. There is no partial state after reset is released.

Optional Feature:
ROW_WINDOW_FIFO_LEVEL_EN
- Defined: adds output port level [CW-1:0] = count, plus output almost_full = (count ≥ DEPTH − ROW_SHIFT), both combinational. level resets to 0.
- Undefined: neither port exists, and all other behaviour is identical.

Test Plan:
- Reset, then push 0..14 (15 words) with defaults → full = 0, window_valid = 1, window_out = {2,1,0}, data_out = 0. One more push of 15 → full = 1. A push of 16 while full → rejected, overflow pulses for 1 cycle, data_out still 0.
- From full (0..15), pop once → data_out = 1. pop_row → window_out = {6,5,4}, row_shift_rdy = 1, count = 12.
- pop and pop_row together with count 12 → only ROW_SHIFT removed, count = 9, data_out = 7, no underflow.
- Drain to 2 entries → row_shift_rdy = 0, window_valid = 0, window_out = {0,b,a} with the unused slot 0. pop_row → underflow pulse, contents unchanged.
- Empty FIFO: push 20 with pop same cycle → empty = 0, data_out = 20, window_out = {0,0,20}, underflow = 1 next cycle. Full FIFO with push+pop → count stays 16, no overflow, the new word appears at the tail after wrap.
- Flush at count 9 with push high → empty = 1 next cycle, data_out = 0, no error pulses. Async reset asserted mid-stream → all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/row_window_fifo.sv
// Circular FIFO feeding convolution window builders: single-word push, single or row-step pop, parallel window view.
// Optional macro ROW_WINDOW_FIFO_LEVEL_EN adds level and almost_full outputs.
module row_window_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ROW_SHIFT  = 3,
  parameter int unsigned WINDOW     = 3,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        push_data,
  input  logic                         pop,
  input  logic                         pop_row,
  input  logic                         flush,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [WINDOW*DATA_WIDTH-1:0] window_out,
  output logic                         window_valid,
  output logic                         row_shift_rdy,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  output logic                         underflow
`ifdef ROW_WINDOW_FIFO_LEVEL_EN
  ,
  output logic [CW-1:0]                level,
  output logic                         almost_full
`endif
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned PW1 = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_row_acc;
  logic                  w_pop_acc;
  logic                  w_push_acc;
  logic                  w_overflow_nxt;
  logic                  w_underflow_nxt;
  logic [CW-1:0]         w_count_nxt;

  // Pointer advance modulo DEPTH; inc never exceeds DEPTH so one correction suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [PW:0] inc);
    logic [PW:0] s;
    s = {1'b0, p} + inc;
    if (s >= PW1'(DEPTH)) s = s - PW1'(DEPTH);
    return s[PW-1:0];
  endfunction

  // Request arbitration: flush wins, pop_row shadows pop, push may reuse a slot freed this cycle.
  always_comb begin
    w_row_acc       = 1'b0;
    w_pop_acc       = 1'b0;
    w_push_acc      = 1'b0;
    w_overflow_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
    if (!flush) begin
      w_row_acc       = pop_row && (r_count >= CW'(ROW_SHIFT));
      w_pop_acc       = pop && !pop_row && (r_count != '0);
      w_push_acc      = push && ((r_count < CW'(DEPTH)) || w_row_acc || w_pop_acc);
      w_overflow_nxt  = push && !w_push_acc;
      w_underflow_nxt = (pop_row && !w_row_acc) || (pop && !pop_row && (r_count == '0));
    end
    w_count_nxt = r_count + CW'(w_push_acc) - CW'(w_pop_acc)
                - (w_row_acc ? CW'(ROW_SHIFT) : CW'(0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_count <= w_count_nxt;
        if (w_row_acc)      r_head <= wrap_add(r_head, PW1'(ROW_SHIFT));
        else if (w_pop_acc) r_head <= wrap_add(r_head, PW1'(1));
        if (w_push_acc) begin
          r_mem[r_tail] <= push_data;
          r_tail        <= wrap_add(r_tail, PW1'(1));
        end
      end
    end
  end

  // Window slots beyond the current occupancy read as zero.
  always_comb begin
    window_out = '0;
    for (int unsigned i = 0; i < WINDOW; i++) begin
      if (CW'(i) < r_count)
        window_out[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[wrap_add(r_head, PW1'(i))];
    end
  end

  assign empty         = (r_count == '0);
  assign full          = (r_count == CW'(DEPTH));
  assign data_out      = empty ? '0 : r_mem[r_head];
  assign window_valid  = (r_count >= CW'(WINDOW));
  assign row_shift_rdy = (r_count >= CW'(ROW_SHIFT));
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

`ifdef ROW_WINDOW_FIFO_LEVEL_EN
  assign level       = r_count;
  assign almost_full = (r_count >= CW'(DEPTH - ROW_SHIFT));
`endif

endmodule

// File: tb/tb_row_window_fifo.sv
// Directed self-checking bench for row_window_fifo at default parameters (DEPTH 16, ROW_SHIFT 3, WINDOW 3).
module tb_row_window_fifo;

  logic        clock;
  logic        reset;
  logic        push;
  logic [7:0]  push_data;
  logic        pop;
  logic        pop_row;
  logic        flush;
  logic [7:0]  data_out;
  logic [23:0] window_out;
  logic        window_valid;
  logic        row_shift_rdy;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        underflow;

  int tests;
  int errors;

  row_window_fifo dut (
    .clock        (clock),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .pop          (pop),
    .pop_row      (pop_row),
    .flush        (flush),
    .data_out     (data_out),
    .window_out   (window_out),
    .window_valid (window_valid),
    .row_shift_rdy(row_shift_rdy),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; pop_row = 1'b0; flush = 1'b0; push_data = '0;
  endtask

  task automatic do_push(input logic [7:0] v);
    push = 1'b1; push_data = v;
    tick();
    idle();
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_pop_row();
    pop_row = 1'b1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #12;
    tests++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
    tests++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    tests++; if ({window_valid, row_shift_rdy, overflow, underflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {window_valid, row_shift_rdy, overflow, underflow}); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 15; i++) do_push(8'(i));
    tests++; if (full !== 1'b0) begin errors++; $display("FAIL fill15_full: got %b want 0", full); end
    tests++; if (window_valid !== 1'b1) begin errors++; $display("FAIL fill15_wvalid: got %b want 1", window_valid); end
    tests++; if (window_out !== 24'h020100) begin errors++; $display("FAIL fill15_window: got %h want 020100", window_out); end
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL fill15_data: got %h want 00", data_out); end
    do_push(8'd15);
    tests++; if (full !== 1'b1) begin errors++; $display("FAIL fill16_full: got %b want 1", full); end
    do_push(8'd16);
    tests++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL ovf_data: got %h want 00", data_out); end
    tests++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
    tick();
    tests++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_pop();
    do_pop();
    tests++; if (data_out !== 8'h01) begin errors++; $display("FAIL pop_data: got %h want 01", data_out); end
    tests++; if (full !== 1'b0) begin errors++; $display("FAIL pop_full: got %b want 0", full); end
    do_pop_row();
    tests++; if (window_out !== 24'h060504) begin errors++; $display("FAIL poprow_window: got %h want 060504", window_out); end
    tests++; if (row_shift_rdy !== 1'b1) begin errors++; $display("FAIL poprow_rdy: got %b want 1", row_shift_rdy); end
  endtask

  task automatic test_pop_both();
    pop = 1'b1; pop_row = 1'b1;
    tick();
    idle();
    tests++; if (data_out !== 8'h07) begin errors++; $display("FAIL both_data: got %h want 07", data_out); end
    tests++; if (window_out !== 24'h090807) begin errors++; $display("FAIL both_window: got %h want 090807", window_out); end
    tests++; if (underflow !== 1'b0) begin errors++; $display("FAIL both_udf: got %b want 0", underflow); end
  endtask

  task automatic test_drain_underflow();
    do_pop_row();
    do_pop_row();
    do_pop();
    tests++; if (row_shift_rdy !== 1'b0) begin errors++; $display("FAIL drain_rdy: got %b want 0", row_shift_rdy); end
    tests++; if (window_valid !== 1'b0) begin errors++; $display("FAIL drain_wvalid: got %b want 0", window_valid); end
    tests++; if (window_out !== 24'h000F0E) begin errors++; $display("FAIL drain_window: got %h want 000f0e", window_out); end
    do_pop_row();
    tests++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_pulse: got %b want 1", underflow); end
    tests++; if (window_out !== 24'h000F0E) begin errors++; $display("FAIL udf_window: got %h want 000f0e", window_out); end
    tick();
    tests++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_empty_push_pop();
    do_pop();
    do_pop();
    tests++; if (empty !== 1'b1) begin errors++; $display("FAIL epp_pre_empty: got %b want 1", empty); end
    push = 1'b1; push_data = 8'd20; pop = 1'b1;
    tick();
    idle();
    tests++; if (empty !== 1'b0) begin errors++; $display("FAIL epp_empty: got %b want 0", empty); end
    tests++; if (data_out !== 8'h14) begin errors++; $display("FAIL epp_data: got %h want 14", data_out); end
    tests++; if (window_out !== 24'h000014) begin errors++; $display("FAIL epp_window: got %h want 000014", window_out); end
    tests++; if (underflow !== 1'b1) begin errors++; $display("FAIL epp_udf: got %b want 1", underflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 15; i++) do_push(8'(100 + i));
    tests++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_pre_full: got %b want 1", full); end
    push = 1'b1; push_data = 8'd200; pop = 1'b1;
    tick();
    idle();
    tests++; if (full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b want 1", full); end
    tests++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b want 0", overflow); end
    tests++; if (data_out !== 8'd100) begin errors++; $display("FAIL fpp_data: got %h want 64", data_out); end
    for (int i = 0; i < 15; i++) do_pop();
    tests++; if (data_out !== 8'd200) begin errors++; $display("FAIL fpp_tail: got %h want c8", data_out); end
    tests++; if (window_out !== 24'h0000C8) begin errors++; $display("FAIL fpp_window: got %h want 0000c8", window_out); end
    do_pop();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 9; i++) do_push(8'(30 + i));
    tests++; if (data_out !== 8'd30) begin errors++; $display("FAIL flush_pre: got %h want 1e", data_out); end
    flush = 1'b1; push = 1'b1; push_data = 8'd99;
    tick();
    idle();
    tests++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL flush_data: got %h want 00", data_out); end
    tests++; if (window_out !== 24'h0) begin errors++; $display("FAIL flush_window: got %h want 000000", window_out); end
    tests++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL flush_err: got %b want 00", {overflow, underflow}); end
    do_push(8'd5);
    tests++; if (data_out !== 8'd5) begin errors++; $display("FAIL flush_after: got %h want 05", data_out); end
    do_pop();
  endtask

  task automatic test_async_reset();
    do_push(8'd7);
    do_push(8'd8);
    do_pop_row();
    tests++; if (underflow !== 1'b1) begin errors++; $display("FAIL ar_pre_udf: got %b want 1", underflow); end
    #2 reset = 1'b0;
    #1;
    tests++; if (underflow !== 1'b0) begin errors++; $display("FAIL ar_udf: got %b want 0", underflow); end
    tests++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_empty: got %b want 1", empty); end
    tests++; if (data_out !== 8'h00) begin errors++; $display("FAIL ar_data: got %h want 00", data_out); end
    tests++; if (window_out !== 24'h0) begin errors++; $display("FAIL ar_window: got %h want 000000", window_out); end
    #10 reset = 1'b1;
    tick();
    do_push(8'd1);
    tests++; if (window_out !== 24'h000001) begin errors++; $display("FAIL ar_after: got %h want 000001", window_out); end
  endtask

  initial begin
    tests = 0;
    errors = 0;
    idle();
    reset = 1'b1;
    test_reset();
    test_fill();
    test_pop();
    test_pop_both();
    test_drain_underflow();
    test_empty_push_pop();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
